// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - coprocessor-0 register file with exception commit and Count/Compare timer
//
// Purpose:
//   Holds the CP0 registers used by the pipeline: BadVAddr, Count, Compare,
//   Status, Cause, EPC and PRId. Services MTC0 writes and MFC0 reads, commits
//   the prioritised exception from the exception encoder, and runs the
//   Count/Compare timer that raises the timer interrupt.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   we_i, waddr_i,       MTC0 write enable, destination register, data
//   data_i
//   raddr_i, data_o      MFC0 source register and combinational read data
//   int_i                external interrupt lines IP7..IP2
//   excepttype_i         prioritised exception code, 0 when none
//   current_inst_addr_i  PC of the excepting instruction
//   is_in_delayslot_i    excepting instruction sits in a branch delay slot
//   bad_addr_i           faulting address for address-error exceptions
//   count_o .. badvaddr_o current register values for the pipeline
//   timer_int_o          sticky timer interrupt pending flag
module cp0_regfile #(
   parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
   parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [4:0]  raddr_i,
   input  logic [31:0] data_i,
   input  logic [5:0]  int_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] current_inst_addr_i,
   input  logic        is_in_delayslot_i,
   input  logic [31:0] bad_addr_i,
   output logic [31:0] data_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] badvaddr_o,
   output logic        timer_int_o
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;

   logic [31:0] count_r;
   logic [31:0] compare_r;
   logic [31:0] status_r;
   logic [31:0] cause_r;
   logic [31:0] epc_r;
   logic [31:0] badvaddr_r;
   logic        timer_r;
   logic        tick_r;

   // Exception decode: which codes commit state and what ExcCode they carry.
   logic        exc_commit;
   logic        exc_eret;
   logic        exc_addr_err;
   logic [4:0]  exc_code;

   always_comb begin
      exc_commit   = 1'b1;
      exc_eret     = 1'b0;
      exc_addr_err = 1'b0;
      exc_code     = 5'd0;
      case (excepttype_i)
         32'h1:   exc_code = 5'd0;
         32'h4:   begin exc_code = 5'd4; exc_addr_err = 1'b1; end
         32'h5:   begin exc_code = 5'd5; exc_addr_err = 1'b1; end
         32'h8:   exc_code = 5'd8;
         32'h9:   exc_code = 5'd9;
         32'ha:   exc_code = 5'd10;
         32'hc:   exc_code = 5'd12;
         32'he:   begin exc_commit = 1'b0; exc_eret = 1'b1; end
         default: exc_commit = 1'b0;
      endcase
   end

   logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   logic exc_any;

   // Any nonzero exception code takes the Status/Cause/EPC write ports away
   // from MTC0 for this cycle; Count and Compare are not touched by exceptions.
   assign exc_any    = (excepttype_i != 32'd0);
   assign wr_count   = we_i && (waddr_i == REG_COUNT);
   assign wr_compare = we_i && (waddr_i == REG_COMPARE);
   assign wr_status  = we_i && (waddr_i == REG_STATUS) && !exc_any;
   assign wr_cause   = we_i && (waddr_i == REG_CAUSE)  && !exc_any;
   assign wr_epc     = we_i && (waddr_i == REG_EPC)    && !exc_any;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_r    <= 32'd0;
         compare_r  <= 32'd0;
         status_r   <= STATUS_RESET;
         cause_r    <= 32'd0;
         epc_r      <= 32'd0;
         badvaddr_r <= 32'd0;
         timer_r    <= 1'b0;
         tick_r     <= 1'b0;
      end else begin
         // Count advances on every second cycle; a load restarts the phase.
         if (wr_count) begin
            count_r <= data_i;
            tick_r  <= 1'b0;
         end else begin
            tick_r <= ~tick_r;
            if (tick_r)
               count_r <= count_r + 32'd1;
         end

         if (wr_compare)
            compare_r <= data_i;

         // Compare write acknowledges the interrupt and beats a new match.
         if (wr_compare)
            timer_r <= 1'b0;
         else if ((compare_r != 32'd0) && (count_r == compare_r))
            timer_r <= 1'b1;

         // IP7 carries the timer interrupt alongside int_i[5].
         cause_r[15:10] <= {int_i[5] | timer_r, int_i[4:0]};

         if (wr_status) begin
            status_r[15:8] <= data_i[15:8];
            status_r[1:0]  <= data_i[1:0];
         end
         if (wr_cause)
            cause_r[9:8] <= data_i[9:8];
         if (wr_epc)
            epc_r <= data_i;

         if (exc_commit) begin
            // A nested exception under EXL keeps the original return point.
            if (!status_r[1]) begin
               epc_r       <= is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                : current_inst_addr_i;
               cause_r[31] <= is_in_delayslot_i;
               status_r[1] <= 1'b1;
            end
            cause_r[6:2] <= exc_code;
            if (exc_addr_err)
               badvaddr_r <= bad_addr_i;
         end else if (exc_eret) begin
            status_r[1] <= 1'b0;
         end
      end
   end

   always_comb begin
      data_o = 32'd0;
      case (raddr_i)
         REG_BADVADDR: data_o = badvaddr_r;
         REG_COUNT:    data_o = count_r;
         REG_COMPARE:  data_o = compare_r;
         REG_STATUS:   data_o = status_r;
         REG_CAUSE:    data_o = cause_r;
         REG_EPC:      data_o = epc_r;
         REG_PRID:     data_o = PRID_VALUE;
         default:      data_o = 32'd0;
      endcase
   end

   assign count_o     = count_r;
   assign compare_o   = compare_r;
   assign status_o    = status_r;
   assign cause_o     = cause_r;
   assign epc_o       = epc_r;
   assign badvaddr_o  = badvaddr_r;
   assign timer_int_o = timer_r;

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
Coprocessor-0 register file that consumes the prioritised exception code produced by the pipeline's exception encoder. It also services MTC0/MFC0 accesses. It commits exception state (EPC, Cause.BD/ExcCode, Status.EXL, BadVAddr) and returns Status/Cause to the encoder for interrupt qualification. It owns the Count/Compare timer and raises the timer interrupt. It sits at the MEM/WB boundary beside the exception encoder.

Parameters:
PRID_VALUE, 32'h0000_4220, constant returned on reads of register 15.
STATUS_RESET, 32'h0040_0000, Status value after reset (BEV=1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
we_i  in  1  MTC0 write enable
waddr_i  in  5  MTC0 destination register number
raddr_i  in  5  MFC0 source register number
data_i  in  32  MTC0 write data
int_i  in  6  external hardware interrupt lines (IP7..IP2)
excepttype_i  in  32  prioritised exception code (0 = none)
current_inst_addr_i  in  32  PC of the excepting instruction
is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot
bad_addr_i  in  32  faulting address for AdEL/AdES
data_o  out  32  MFC0 read data
count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  out  32 each  current register values
timer_int_o  out  1  timer interrupt pending

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All updates occur on the rising edge of clk.
- Reset values:
  - count, compare, cause, epc, badvaddr = 0.
  - status = STATUS_RESET.
  - timer_int_o = 0.
  - Internal count tick bit = 0.
- Register map:
  - 8 BadVAddr: read-only to software.
  - 9 Count.
  - 11 Compare.
  - 12 Status.
  - 13 Cause.
  - 14 EPC.
  - 15 PRId: reads PRID_VALUE.
  - All other numbers read 0; writes to them are ignored.
- Read path: data_o is combinational from current register contents. It shows the pre-edge value; there is no same-cycle write bypass.
- Write masks:
  - Count: all 32 bits.
  - Compare: all 32 bits.
  - EPC: all 32 bits.
  - Status: only bits [15:8], [1], [0]; other bits hold.
  - Cause: only bits [9:8] (software interrupts); other bits hold.
  - BadVAddr: writes ignored.
- Timer:
  - Tick toggles every cycle; count increments when tick==1, i.e. every 2nd cycle. Count wraps 32'hFFFF_FFFF -> 0.
  - Writing Count loads data_i and clears tick.
  - When compare != 0 and count == compare, timer_int_o is set and stays set (sticky).
  - A write to Compare clears timer_int_o in that cycle. The clear has priority over a set.
- Cause[15:10] is updated every cycle from {int_i[5] | timer_int_o, int_i[4:0]}.
- Exception commit (when excepttype_i != 0):
  - Exception commit takes priority over an MTC0 to the same register in the same cycle. The MTC0 is dropped for Status, Cause and EPC.
  - Codes 1, 4, 5, 8, 9, 'a', 'c' map to ExcCode 0, 4, 5, 8, 9, 10, 12 respectively.
  - For those codes, when Status.EXL == 0:
    - EPC = current_inst_addr_i - 4 and Cause[31] (BD) = 1 if is_in_delayslot_i; otherwise EPC = current_inst_addr_i and BD = 0.
    - Status.EXL (bit 1) = 1.
    - Cause[6:2] = ExcCode.
  - When Status.EXL == 1 already: EPC and BD hold; ExcCode is still updated.
  - Codes 4 and 5 additionally load badvaddr = bad_addr_i.
  - Code 'e' (eret): Status.EXL = 0; nothing else changes.
  - Any other nonzero code: no state change.
- A timer set and an exception commit in the same cycle are both applied.
- Reset asserted mid-operation overrides everything and returns all state to reset values on that edge.

Test Plan:
- Reset, then read regs 12/13/15 -> data_o = 0040_0000 / 0 / 0000_4220; timer_int_o = 0.
- MTC0 Compare = 10, Count = 0; run 20 cycles -> count reaches 10 and timer_int_o = 1, cause[15] = 1. Write Compare = 0x20 -> timer_int_o = 0 on the next edge.
- excepttype 4 at PC 0xBFC0_0100, delay slot = 1, bad_addr 0x1003 -> epc = 0xBFC0_00FC, cause[31] = 1, cause[6:2] = 4, status[1] = 1, badvaddr = 0x1003.
- With EXL = 1, excepttype 0xC at PC 0x200 -> epc unchanged, ExcCode = 12. Then excepttype 0xE -> status[1] = 0.
- Same cycle: MTC0 EPC = 0x1234 and excepttype 8 at PC 0x400 (EXL = 0) -> epc = 0x400, ExcCode = 8.
- MTC0 Status = 0xFFFF_FFFF -> status = 0x0040_FF03. MTC0 Cause = 0xFFFF_FFFF -> only cause[9:8] set.
